// File: rtl/mem_pkg.sv
// Shared encodings and small helpers for the load/store path between the CPU
// datapath and the word-wide dram.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LHU);
    endfunction

    function automatic logic is_sub_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (is_word(op) && (a != 2'b00)) || (is_half(op) && a[0]);
    endfunction

    // Used when misalignment is tolerated: drop the offending low bits.
    function automatic logic [31:0] align_addr(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] r;
        r = a;
        if (is_word(op)) r[1:0] = 2'b00;
        else if (is_half(op)) r[0] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_unit.sv
// Byte/half lane logic: extracts and extends a load from the read word and
// builds the merged word for stores (little-endian lanes).
module lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  a_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword_i[{a_i, 3'b000} +: 8];
        half_sel = a_i[1] ? rword_i[31:16] : rword_i[15:0];

        load_o = rword_i;
        case (op_i)
            OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o = {24'h0, byte_sel};
            OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o = {16'h0, half_sel};
            default: load_o = rword_i;
        endcase

        merge_o = rword_i;
        case (op_i)
            OP_SW: merge_o = wdata_i;
            OP_SB: merge_o[{a_i, 3'b000} +: 8] = wdata_i[7:0];
            OP_SH: begin
                if (a_i[1]) merge_o[31:16] = wdata_i[15:0];
                else        merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = rword_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store controller: turns MIPS memory ops into word
// reads/writes on the dram port; sub-word stores are read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic        ERR_ON_MISALIGN = 1'b1,
    parameter logic [31:0] LOAD_RESET      = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        dm_ena,
    output logic        dm_wena,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  dbg_state_o
);

    // CPU handshake: req is sampled only in IDLE; busy is high from the accept
    // edge until FIN ends; done pulses for exactly the FIN cycle with err valid.
    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, rword_q, load_data_q, dm_addr_q, dm_wdata_q;
    logic        err_q;
    logic        mis_err;
    logic [31:0] lane_rword, lane_load, lane_merge;

    assign mis_err = ERR_ON_MISALIGN && misaligned(op, addr[1:0]);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mis_err)          state_d = FIN;
                    else if (op == OP_SW) state_d = WR;
                    else                  state_d = RD;
                end
            end
            RD:      state_d = is_load(op_q) ? FIN : WR;
            WR:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In RD the word comes straight off the bus so a load completes at that edge.
    assign lane_rword = (state_q == RD) ? dm_rdata : rword_q;

    lane_unit u_lane (
        .rword_i (lane_rword),
        .a_i     (addr_q[1:0]),
        .op_i    (op_q),
        .wdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            op_q        <= OP_LW;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rword_q     <= 32'h0;
            load_data_q <= LOAD_RESET;
            err_q       <= 1'b0;
            dm_addr_q   <= 32'h0;
            dm_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= align_addr(op, addr);
                        wdata_q <= wdata;
                        err_q   <= mis_err;
                        if (mis_err) load_data_q <= LOAD_RESET;
                    end
                end
                RD: begin
                    rword_q   <= dm_rdata;
                    dm_addr_q <= dm_addr;
                    if (is_load(op_q)) load_data_q <= lane_load;
                end
                WR: begin
                    dm_addr_q  <= dm_addr;
                    dm_wdata_q <= lane_merge;
                end
                default: ;
            endcase
        end
    end

    assign dm_ena      = (state_q == RD);
    assign dm_wena     = (state_q == WR);
    assign dm_addr     = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : dm_addr_q;
    assign dm_wdata    = (state_q == WR) ? lane_merge : dm_wdata_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign err         = err_q;
    assign load_data   = load_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural dram, word-array reference model,
// directed spec cases plus randomized op/address/data mix.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        dm_ena, dm_wena;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] dram [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] ld_model;
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_val;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK(CLK), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .dm_ena(dm_ena), .dm_wena(dm_wena), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dbg_state_o(dbg_state)
    );

    assign dm_rdata = dram[dm_addr[9:2]];

    always @(posedge CLK) begin
        if (dm_wena)    dram[dm_addr[9:2]] <= dm_wdata;
        else if (tb_we) dram[tb_idx] <= tb_val;
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge CLK);
        tb_we = 1'b1; tb_idx = 8'(idx); tb_val = val;
        ref_mem[idx] = val;
        @(negedge CLK);
        tb_we = 1'b0;
    endtask

    // Drive one request and observe the handshake until done (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int lat, output logic e,
                          output logic [31:0] ld, output int n_ena, output int n_wena,
                          output logic [31:0] last_wd);
        @(negedge CLK);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(posedge CLK);
        lat = 0; n_ena = 0; n_wena = 0; e = 1'bx; ld = 32'hx; last_wd = 32'hx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (!hold) req = 1'b0;
            if (dm_ena) n_ena++;
            if (dm_wena) begin n_wena++; last_wd = dm_wdata; end
            if (done) begin lat = k; e = err; ld = load_data; break; end
        end
        req = 1'b0;
    endtask

    // Reference: word array plus plain shift/mask arithmetic.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic e, output int n_ena,
                            output int n_wena, output logic [31:0] wd);
        int b, idx;
        logic [31:0] w, v;
        bit wordop, halfop;
        b = int'(a[1:0]); idx = int'(a[9:2]); w = ref_mem[idx];
        wordop = (o == OP_LW || o == OP_SW);
        halfop = (o == OP_LH || o == OP_LHU || o == OP_SH);
        wd = 32'hx;
        if ((wordop && b != 0) || (halfop && (b % 2) == 1)) begin
            lat = 1; e = 1'b1; n_ena = 0; n_wena = 0; ld_model = 32'h0;
            return;
        end
        e = 1'b0;
        if (o <= OP_LHU) begin
            lat = 2; n_ena = 1; n_wena = 0;
            v = (o == OP_LH || o == OP_LHU) ? ((w >> (8 * b)) & 32'hFFFF) : ((w >> (8 * b)) & 32'hFF);
            case (o)
                OP_LW:  ld_model = w;
                OP_LB:  ld_model = (v >= 128) ? v + 32'hFFFF_FF00 : v;
                OP_LH:  ld_model = (v >= 32768) ? v + 32'hFFFF_0000 : v;
                default: ld_model = v;
            endcase
        end else begin
            n_wena = 1;
            if (o == OP_SW) begin lat = 2; n_ena = 0; wd = d; end
            else if (o == OP_SB) begin
                lat = 3; n_ena = 1;
                wd = (w & ~(32'hFF << (8 * b))) | ((d & 32'hFF) << (8 * b));
            end else begin
                lat = 3; n_ena = 1;
                wd = (w & ~(32'hFFFF << (8 * b))) | ((d & 32'hFFFF) << (8 * b));
            end
            ref_mem[idx] = wd;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req = 1'b0; op = OP_LW; addr = 32'h0; wdata = 32'h0; tb_we = 1'b0;
        ld_model = 32'h0;
        repeat (3) @(negedge CLK);
        n_cmp++; if ({busy, done, err, dm_ena, dm_wena} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b want=00000", {busy, done, err, dm_ena, dm_wena}); end
        n_cmp++; if (load_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_load_data got=%h want=00000000", load_data); end
        n_cmp++; if ({dm_addr, dm_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_dm_bus got=%h/%h want=0/0", dm_addr, dm_wdata); end
        rst = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  t_op  [4] = '{OP_LB, OP_LBU, OP_LHU, OP_LH};
        logic [31:0] t_off [4] = '{32'd1, 32'd3, 32'd2, 32'd0};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'h0000_8899, 32'hFFFF_AABB};
        int lat, ne, nw, mlat, mne, mnw;
        logic e, me;
        logic [31:0] ld, wd, mwd;
        for (int i = 0; i < 4; i++) begin
            model_op(t_op[i], BASE + t_off[i], 32'h0, mlat, me, mne, mnw, mwd);
            run_op(t_op[i], BASE + t_off[i], 32'h0, 1'b0, lat, e, ld, ne, nw, wd);
            n_cmp++; if (ld !== t_exp[i] || lat != 2 || e !== 1'b0) begin
                n_fail++; $display("FAIL load_%0d got ld=%h lat=%0d err=%b want ld=%h lat=2 err=0", i, ld, lat, e, t_exp[i]); end
            n_cmp++; if (ne != 1 || nw != 0) begin
                n_fail++; $display("FAIL load_traffic_%0d got ena=%0d wena=%0d want 1/0", i, ne, nw); end
        end
    endtask

    task automatic test_stores;
        int lat, ne, nw, mlat, mne, mnw;
        logic e, me;
        logic [31:0] ld, wd, mwd;
        model_op(OP_SB, BASE + 2, 32'h11, mlat, me, mne, mnw, mwd);
        run_op(OP_SB, BASE + 2, 32'h11, 1'b0, lat, e, ld, ne, nw, wd);
        n_cmp++; if (lat != 3 || ne != 1 || nw != 1 || wd !== 32'h8811_AABB) begin
            n_fail++; $display("FAIL sb got lat=%0d ena=%0d wena=%0d wd=%h want 3/1/1/8811aabb", lat, ne, nw, wd); end
        model_op(OP_LW, BASE, 32'h0, mlat, me, mne, mnw, mwd);
        run_op(OP_LW, BASE, 32'h0, 1'b0, lat, e, ld, ne, nw, wd);
        n_cmp++; if (ld !== 32'h8811_AABB || lat != 2) begin
            n_fail++; $display("FAIL lw_after_sb got ld=%h lat=%0d want 8811aabb/2", ld, lat); end
        model_op(OP_SW, BASE + 4, 32'hDEAD_BEEF, mlat, me, mne, mnw, mwd);
        run_op(OP_SW, BASE + 4, 32'hDEAD_BEEF, 1'b0, lat, e, ld, ne, nw, wd);
        n_cmp++; if (lat != 2 || ne != 0 || nw != 1 || wd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw got lat=%0d ena=%0d wena=%0d wd=%h want 2/0/1/deadbeef", lat, ne, nw, wd); end
        model_op(OP_SH, BASE + 6, 32'h1234, mlat, me, mne, mnw, mwd);
        run_op(OP_SH, BASE + 6, 32'h1234, 1'b0, lat, e, ld, ne, nw, wd);
        model_op(OP_LW, BASE + 4, 32'h0, mlat, me, mne, mnw, mwd);
        run_op(OP_LW, BASE + 4, 32'h0, 1'b0, lat, e, ld, ne, nw, wd);
        n_cmp++; if (ld !== 32'h1234_BEEF) begin
            n_fail++; $display("FAIL lw_after_sh got=%h want=1234beef", ld); end
    endtask

    task automatic test_misalign_hold;
        int lat, ne, nw, mlat, mne, mnw, extra;
        logic e, me;
        logic [31:0] ld, wd, mwd;
        model_op(OP_LW, BASE + 2, 32'h0, mlat, me, mne, mnw, mwd);
        run_op(OP_LW, BASE + 2, 32'h0, 1'b1, lat, e, ld, ne, nw, wd);
        n_cmp++; if (lat != 1 || e !== 1'b1 || ld !== 32'h0) begin
            n_fail++; $display("FAIL misalign got lat=%0d err=%b ld=%h want 1/1/0", lat, e, ld); end
        n_cmp++; if (ne != 0 || nw != 0) begin
            n_fail++; $display("FAIL misalign_traffic got ena=%0d wena=%0d want 0/0", ne, nw); end
        extra = 0;
        repeat (4) begin @(negedge CLK); if (busy || dm_ena || dm_wena) extra++; end
        n_cmp++; if (extra != 0) begin
            n_fail++; $display("FAIL held_req_single got extra_busy=%0d want 0", extra); end
        model_op(OP_LW, BASE, 32'h0, mlat, me, mne, mnw, mwd);
        run_op(OP_LW, BASE, 32'h0, 1'b0, lat, e, ld, ne, nw, wd);
        n_cmp++; if (e !== 1'b0 || ld !== ld_model) begin
            n_fail++; $display("FAIL err_clear got err=%b ld=%h want 0/%h", e, ld, ld_model); end
    endtask

    task automatic test_random;
        int lat, ne, nw, mlat, mne, mnw;
        logic e, me;
        logic [31:0] ld, wd, mwd, a, d;
        logic [2:0] o;
        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 7));
            a = BASE + 32'($urandom_range(0, 63));
            d = $urandom;
            model_op(o, a, d, mlat, me, mne, mnw, mwd);
            run_op(o, a, d, 1'($urandom_range(0, 1)), lat, e, ld, ne, nw, wd);
            n_cmp++; if (lat != mlat || e !== me || ne != mne || nw != mnw) begin
                n_fail++; $display("FAIL rand_%0d op=%0d a=%h got lat=%0d err=%b ena=%0d wena=%0d want %0d/%b/%0d/%0d",
                                   i, o, a, lat, e, ne, nw, mlat, me, mne, mnw); end
            if (o <= OP_LHU || me) begin
                n_cmp++; if (ld !== ld_model) begin
                    n_fail++; $display("FAIL rand_ld_%0d op=%0d a=%h got=%h want=%h", i, o, a, ld, ld_model); end
            end
            if (mnw == 1) begin
                n_cmp++; if (wd !== mwd) begin
                    n_fail++; $display("FAIL rand_wd_%0d op=%0d a=%h got=%h want=%h", i, o, a, wd, mwd); end
            end
        end
    endtask

    task automatic test_reset_mid_sb;
        int guard;
        @(negedge CLK);
        req = 1'b1; op = OP_SB; addr = BASE + 9; wdata = 32'h5A;
        @(posedge CLK);
        @(negedge CLK); req = 1'b0;
        guard = 0;
        while (!dm_wena && guard < 4) begin @(negedge CLK); guard++; end
        n_cmp++; if (dm_wena !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_reach_wr got wena=%b want 1", dm_wena); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({busy, done, dm_wena} !== 3'b000 || dm_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_async got busy/done/wena=%b dm_addr=%h want 000/0", {busy, done, dm_wena}, dm_addr); end
        @(posedge CLK); #1;
        n_cmp++; if (dram[2] !== ref_mem[2]) begin
            n_fail++; $display("FAIL mid_reset_mem got=%h want=%h", dram[2], ref_mem[2]); end
        ld_model = 32'h0;
        @(negedge CLK); rst = 1'b1;
        guard = 0;
        repeat (3) begin @(negedge CLK); if (done) guard++; end
        n_cmp++; if (guard != 0 || load_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_no_done got dones=%0d ld=%h want 0/0", guard, load_data); end
    endtask

    initial begin
        test_reset;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(0, 32'h8899_AABB);
        preload(1, 32'h0000_0000);
        test_loads;
        test_stores;
        test_misalign_hold;
        test_random;
        test_reset_mid_sb;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (dram[i] !== ref_mem[i]) begin
                n_fail++; $display("FAIL final_mem_%0d got=%h want=%h", i, dram[i], ref_mem[i]); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
